usb_ep_in_mbuf: RTL and testbench

Parametrised multi-bank IN-endpoint packet buffer, the successor to the single fixed 512x8 buf_in interface of the USB device core.
- User logic fills banks through the same addr/data/wren/commit/commit_ack handshake as before.
- The protocol layer drains committed packets in FIFO order, with consume and retry (NAK/retransmit) semantics.
- Sits between user logic and the usb2/usb3 protocol engines, on the core's local clock.

---
 rtl/usb_buf_pkg.sv | 23 ++
 rtl/usb_buf_dpram.sv | 24 ++
 rtl/usb_ep_in_mbuf.sv | 127 ++++++++++++
 tb/tb_usb_ep_in_mbuf.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_buf_pkg.sv
// Shared types and constants for the multi-bank IN-endpoint packet buffer.
package usb_buf_pkg;

    typedef enum logic [1:0] {
        C_IDLE,
        C_ACK,
        C_WAIT
    } commit_state_e;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 9;
    localparam int DEF_NUM_BANKS = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/usb_buf_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module usb_buf_dpram #(
    parameter int DATA_W = 8,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/usb_ep_in_mbuf.sv
// Multi-bank IN-endpoint packet buffer: user logic fills and commits banks,
// the protocol engine drains them in FIFO order with consume/retry semantics.
module usb_ep_in_mbuf
    import usb_buf_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int LEN_W     = ADDR_W + 1
) (
    input  logic                        ext_clk,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           buf_in_addr,
    input  logic [DATA_W-1:0]           buf_in_data,
    input  logic                        buf_in_wren,
    output logic                        buf_in_ready,
    input  logic                        buf_in_commit,
    input  logic [LEN_W-1:0]            buf_in_commit_len,
    output logic                        buf_in_commit_ack,
    output logic                        pkt_avail,
    output logic [LEN_W-1:0]            pkt_len,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic [DATA_W-1:0]           rd_q,
    input  logic                        pkt_done,
    input  logic                        pkt_flush,
    output logic [clog2(NUM_BANKS):0]   banks_used,
    output logic                        err_ovf
);

    localparam int PTR_W = clog2(NUM_BANKS);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(2**ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_BANKS);

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [LEN_W-1:0]  len_reg [NUM_BANKS];
    commit_state_e     state, state_d;
    logic              commit_acc, commit_err, done_acc, ready;
    logic              rd_vld_p1;
    logic [DATA_W-1:0] ram_q;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_MAX) ? LEN_MAX : len;
    endfunction

    assign ready             = (count < CNT_FULL);
    assign buf_in_ready      = ready;
    assign pkt_avail         = (count != '0);
    assign pkt_len           = pkt_avail ? len_reg[rd_ptr] : '0;
    assign banks_used        = count;
    assign buf_in_commit_ack = (state == C_ACK) && !pkt_flush;
    assign done_acc          = pkt_done && pkt_avail && !pkt_flush;
    assign rd_q              = rd_vld_p1 ? ram_q : '0;

    always_comb begin
        state_d    = state;
        commit_acc = 1'b0;
        commit_err = 1'b0;
        unique case (state)
            C_IDLE: begin
                if (buf_in_commit) begin
                    if (ready) begin
                        commit_acc = 1'b1;
                        state_d    = C_ACK;
                    end else begin
                        commit_err = 1'b1;
                    end
                end
            end
            C_ACK:  state_d = C_WAIT;
            C_WAIT: if (!buf_in_commit) state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase
        // A flush cancels any same-cycle commit; a held level must drop before re-arming.
        if (pkt_flush) begin
            commit_acc = 1'b0;
            state_d    = buf_in_commit ? C_WAIT : C_IDLE;
        end
    end

    always_ff @(posedge ext_clk) begin
        if (reset) begin
            state     <= C_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            err_ovf   <= 1'b0;
            rd_vld_p1 <= 1'b0;
        end else begin
            state     <= state_d;
            err_ovf   <= (buf_in_wren && !ready) || commit_err;
            rd_vld_p1 <= 1'b1;
            if (pkt_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (commit_acc) wr_ptr <= wr_ptr + PTR_W'(1);
                if (done_acc)   rd_ptr <= rd_ptr + PTR_W'(1);
                unique case ({commit_acc, done_acc})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge ext_clk) begin
        if (commit_acc) len_reg[wr_ptr] <= clamp_len(buf_in_commit_len);
    end

    // Read port always addresses the head bank; fill writes go to the tail bank.
    usb_buf_dpram #(
        .DATA_W (DATA_W),
        .AW     (PTR_W + ADDR_W)
    ) u_ram (
        .clk     (ext_clk),
        .wr_en   (buf_in_wren && ready),
        .wr_addr ({wr_ptr, buf_in_addr}),
        .wr_data (buf_in_data),
        .rd_addr ({rd_ptr, rd_addr}),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_usb_ep_in_mbuf.sv
// Bench for usb_ep_in_mbuf: directed scenarios plus random traffic against a queue-based model.
module tb_usb_ep_in_mbuf;

    localparam int DW = 8;
    localparam int AW = 9;
    localparam int NB = 2;
    localparam int LW = AW + 1;
    localparam int CW = 2;
    localparam int BANK_WORDS = 2**AW;

    logic          ext_clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data = '0;
    logic          wren = 1'b0;
    logic          commit = 1'b0;
    logic [LW-1:0] clen = '0;
    logic [AW-1:0] rd_addr = '0;
    logic          done = 1'b0;
    logic          flush = 1'b0;

    logic          ready, ack, avail, err_ovf;
    logic [LW-1:0] pkt_len;
    logic [DW-1:0] rd_q;
    logic [CW-1:0] banks_used;

    always #5 ext_clk = ~ext_clk;

    usb_ep_in_mbuf #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .NUM_BANKS (NB),
        .LEN_W     (LW)
    ) dut (
        .ext_clk           (ext_clk),
        .reset             (reset),
        .buf_in_addr       (addr),
        .buf_in_data       (data),
        .buf_in_wren       (wren),
        .buf_in_ready      (ready),
        .buf_in_commit     (commit),
        .buf_in_commit_len (clen),
        .buf_in_commit_ack (ack),
        .pkt_avail         (avail),
        .pkt_len           (pkt_len),
        .rd_addr           (rd_addr),
        .rd_q              (rd_q),
        .pkt_done          (done),
        .pkt_flush         (flush),
        .banks_used        (banks_used),
        .err_ovf           (err_ovf)
    );

    // Reference model: queue of pending packet lengths, index of the bank being filled,
    // and a word-level image of every bank.
    int       q[$];
    int       m_fill;
    bit       m_ack, m_hold, m_err, m_init;
    logic [7:0] mem_m [NB][BANK_WORDS];
    bit       known [NB][BANK_WORDS];
    logic [7:0] rdq_exp;
    bit       rdq_k;
    int       n_tests, n_fail, n_ack;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        int sz, head;
        bit rdy, acc, dn;
        #1;
        if (m_init) check_eq("ack", 32'(ack), 32'(m_ack && !flush));
        if (ack === 1'b1) n_ack++;
        if (reset) begin
            q.delete();
            m_fill = 0; m_ack = 0; m_hold = 0; m_err = 0;
            rdq_exp = '0; rdq_k = 1; m_init = 1;
        end else begin
            sz   = q.size();
            rdy  = (sz < NB);
            head = (m_fill - sz + NB) % NB;
            rdq_k   = known[head][int'(rd_addr)];
            rdq_exp = mem_m[head][int'(rd_addr)];
            m_err   = (wren && !rdy) || (!m_ack && !m_hold && commit && !rdy);
            if (wren && rdy) begin
                mem_m[m_fill][int'(addr)] = data;
                known[m_fill][int'(addr)] = 1;
            end
            if (flush) begin
                q.delete();
                m_fill = 0; m_ack = 0; m_hold = commit;
            end else begin
                acc = !m_ack && !m_hold && commit && rdy;
                dn  = done && (sz > 0);
                if (m_ack) begin
                    m_ack = 0; m_hold = 1;
                end else if (m_hold && !commit) begin
                    m_hold = 0;
                end
                if (dn) void'(q.pop_front());
                if (acc) begin
                    q.push_back((int'(clen) > BANK_WORDS) ? BANK_WORDS : int'(clen));
                    m_fill = (m_fill + 1) % NB;
                    m_ack  = 1;
                end
            end
        end
        @(posedge ext_clk);
        #1;
        check_eq("ready", 32'(ready), 32'(q.size() < NB));
        check_eq("avail", 32'(avail), 32'(q.size() != 0));
        check_eq("pkt_len", 32'(pkt_len), (q.size() != 0) ? 32'(q[0]) : 32'd0);
        check_eq("banks_used", 32'(banks_used), 32'(q.size()));
        check_eq("err_ovf", 32'(err_ovf), 32'(m_err));
        if (rdq_k) check_eq("rd_q", 32'(rd_q), 32'(rdq_exp));
    endtask

    task automatic drive_idle();
        reset = 0; wren = 0; commit = 0; done = 0; flush = 0;
    endtask

    task automatic do_reset();
        reset = 1; wren = 0; commit = 0; done = 0; flush = 0;
        step();
        drive_idle();
    endtask

    task automatic commit_pkt(input int len);
        commit = 1; clen = LW'(len);
        step();
        commit = 0;
        step();
        step();
    endtask

    logic [7:0] pass_q [2][8];
    int a0;

    initial begin
        n_tests = 0; n_fail = 0; n_ack = 0; m_init = 0;

        do_reset();
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_used", 32'(banks_used), 32'd0);
        check_eq("rst_rdq", 32'(rd_q), 32'd0);
        check_eq("rst_ack", 32'(ack), 32'd0);

        // Fill bank 0 with a ramp, hold commit for five cycles.
        for (int a = 0; a < 64; a++) begin
            wren = 1; addr = AW'(a); data = DW'(a);
            step();
        end
        wren = 0; commit = 1; clen = LW'(64); a0 = n_ack;
        repeat (5) step();
        commit = 0;
        step();
        check_eq("t1_acks", 32'(n_ack - a0), 32'd1);
        check_eq("t1_avail", 32'(avail), 32'd1);
        check_eq("t1_len", 32'(pkt_len), 32'd64);
        check_eq("t1_used", 32'(banks_used), 32'd1);
        rd_addr = AW'(10);
        step();
        check_eq("t1_rdq", 32'(rd_q), 32'h0A);

        // Both banks full: overflowing write and commit.
        do_reset();
        commit_pkt(512);
        commit_pkt(0);
        check_eq("t2_ready", 32'(ready), 32'd0);
        wren = 1; addr = AW'(3); data = 8'hEE;
        step();
        wren = 0;
        check_eq("t2_err", 32'(err_ovf), 32'd1);
        a0 = n_ack; commit = 1; clen = LW'(5);
        repeat (3) step();
        commit = 0;
        step();
        step();
        check_eq("t2_noack", 32'(n_ack - a0), 32'd0);
        done = 1;
        step();
        done = 0;
        check_eq("t2_ready2", 32'(ready), 32'd1);
        check_eq("t2_zlp", 32'(pkt_len), 32'd0);

        // Oversize commit length is clamped to the bank size.
        done = 1;
        step();
        done = 0;
        commit_pkt(600);
        check_eq("t3_clamp", 32'(pkt_len), 32'd512);

        // Commit and consume in the same cycle.
        commit = 1; clen = LW'(7); done = 1;
        step();
        done = 0;
        check_eq("t4_ack", 32'(ack), 32'd1);
        check_eq("t4_used", 32'(banks_used), 32'd1);
        check_eq("t4_len", 32'(pkt_len), 32'd7);
        commit = 0;
        step();
        step();

        // Retry: re-read the head bank without releasing it.
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 8; i++) begin
                rd_addr = AW'(i);
                step();
                pass_q[p][i] = rd_q;
            end
        end
        for (int i = 0; i < 8; i++) check_eq("t5_retry", 32'(pass_q[1][i]), 32'(pass_q[0][i]));
        check_eq("t5_used", 32'(banks_used), 32'd1);

        // Flush during the ack cycle with two banks pending.
        do_reset();
        commit_pkt(5);
        commit = 1; clen = LW'(9);
        step();
        flush = 1; a0 = n_ack;
        step();
        flush = 0; commit = 0;
        check_eq("t6_noack", 32'(n_ack - a0), 32'd0);
        check_eq("t6_used", 32'(banks_used), 32'd0);
        check_eq("t6_avail", 32'(avail), 32'd0);
        step();
        wren = 1; addr = '0; data = 8'h5A;
        step();
        wren = 0;
        commit_pkt(3);
        check_eq("t6_len", 32'(pkt_len), 32'd3);
        rd_addr = '0;
        step();
        check_eq("t6_rdq", 32'(rd_q), 32'h5A);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 499) == 0);
            flush   = !reset && ($urandom_range(0, 79) == 0);
            wren    = !reset && ($urandom_range(0, 1) == 1);
            addr    = AW'($urandom_range(0, 15));
            data    = DW'($urandom);
            if ($urandom_range(0, 3) == 0) commit = ~commit;
            clen    = LW'($urandom_range(0, 700));
            done    = ($urandom_range(0, 5) == 0);
            rd_addr = AW'($urandom_range(0, 15));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
